// File: rtl/packet_scheduler.sv
// HDMI data island sequencer and round-robin packet slot arbiter.
// Walks IDLE -> PREAMBLE -> GUARD_LEAD -> PACKET(n x 32) -> GUARD_TRAIL and
// loads one requester's header/subpackets (or a null packet) per 32-clock slot.
module packet_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_PACKETS = 18
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  input  logic                   island_start,
  input  logic [4:0]             room_packets,
  input  logic                   must_send,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*24-1:0]  req_header,
  input  logic [NUM_REQ*224-1:0] req_sub,
  output logic [NUM_REQ-1:0]     grant_ack,
  output logic [23:0]            header,
  output logic [3:0][55:0]       sub,
  output logic                   preamble,
  output logic                   guard,
  output logic                   data_island_period,
  output logic                   busy
);

  localparam int unsigned HDR_W     = 24;
  localparam int unsigned SUB_W     = 56;
  localparam int unsigned SUB_N     = 4;
  localparam int unsigned PKT_W     = SUB_W * SUB_N;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ROOM_W    = 5;
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PRE_LEN   = 8;
  localparam int unsigned GUARD_LEN = 2;
  localparam int unsigned SLOT_LEN  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_GUARD_LEAD,
    ST_PACKET,
    ST_GUARD_TRAIL
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  mask;
  logic [NUM_REQ-1:0]  slot_grant;
  logic [ROOM_W-1:0]   room_eff;
  logic [ROOM_W-1:0]   packets_sent;

  logic [NUM_REQ-1:0]  avail_c;
  logic                arb_found_c;
  logic [IDX_W-1:0]    arb_idx_c;
  logic [IDX_W-1:0]    cand_c;
  logic [IDX_W-1:0]    arb_next_ptr_c;
  logic [NUM_REQ-1:0]  arb_onehot_c;
  logic [HDR_W-1:0]    load_header_c;
  logic [PKT_W-1:0]    load_sub_c;
  logic [ROOM_W-1:0]   room_clamped_c;
  logic [ROOM_W-1:0]   packets_inc_c;
  logic                start_c;
  logic                continue_c;

  // Round-robin search over unmasked requests, starting at the RR pointer.
  always_comb begin
    avail_c     = req & ~mask;
    arb_found_c = 1'b0;
    arb_idx_c   = '0;
    cand_c      = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_c = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (!arb_found_c && avail_c[cand_c]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = cand_c;
      end
    end
  end

  // Slot payload and pointer update for the winning requester (null packet if none).
  always_comb begin
    arb_next_ptr_c = IDX_W'((32'(arb_idx_c) + 32'd1) % NUM_REQ);
    arb_onehot_c   = arb_found_c ? (NUM_REQ'(1) << arb_idx_c) : '0;
    load_header_c  = '0;
    load_sub_c     = '0;
    if (arb_found_c) begin
      load_header_c = req_header[32'(arb_idx_c)*HDR_W +: HDR_W];
      load_sub_c    = req_sub[32'(arb_idx_c)*PKT_W +: PKT_W];
    end
  end

  // Island entry, room clamp and slot continuation decisions.
  always_comb begin
    start_c        = island_start && (room_packets != '0) && ((|req) || must_send);
    room_clamped_c = (32'(room_packets) > MAX_PACKETS) ? ROOM_W'(MAX_PACKETS) : room_packets;
    packets_inc_c  = (32'(packets_sent) < MAX_PACKETS) ? (packets_sent + ROOM_W'(1)) : packets_sent;
    continue_c     = ((32'(packets_sent) + 32'd1) < 32'(room_eff)) && arb_found_c;
  end

  // Island FSM with registered outputs; reset aborts any island in progress.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      rr_ptr             <= '0;
      mask               <= '0;
      slot_grant         <= '0;
      room_eff           <= '0;
      packets_sent       <= '0;
      grant_ack          <= '0;
      header             <= '0;
      sub                <= '0;
      preamble           <= 1'b0;
      guard              <= 1'b0;
      data_island_period <= 1'b0;
      busy               <= 1'b0;
    end else begin
      grant_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state        <= ST_PREAMBLE;
            cnt          <= '0;
            preamble     <= 1'b1;
            busy         <= 1'b1;
            room_eff     <= room_clamped_c;
            packets_sent <= '0;
            mask         <= '0;
          end
        end

        ST_PREAMBLE: begin
          if (cnt == CNT_W'(PRE_LEN - 1)) begin
            state    <= ST_GUARD_LEAD;
            cnt      <= '0;
            preamble <= 1'b0;
            guard    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_GUARD_LEAD: begin
          if (cnt == CNT_W'(GUARD_LEN - 1)) begin
            state              <= ST_PACKET;
            cnt                <= '0;
            guard              <= 1'b0;
            data_island_period <= 1'b1;
            header             <= load_header_c;
            sub                <= load_sub_c;
            slot_grant         <= arb_onehot_c;
            mask               <= mask | arb_onehot_c;
            packets_sent       <= '0;
            if (arb_found_c) begin
              rr_ptr <= arb_next_ptr_c;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_PACKET: begin
          if (cnt == CNT_W'(SLOT_LEN - 2)) begin
            // Ack is registered here so it is visible during slot clock 31.
            grant_ack <= slot_grant;
            cnt       <= cnt + CNT_W'(1);
          end else if (cnt == CNT_W'(SLOT_LEN - 1)) begin
            cnt <= '0;
            if (continue_c) begin
              header       <= load_header_c;
              sub          <= load_sub_c;
              slot_grant   <= arb_onehot_c;
              mask         <= mask | arb_onehot_c;
              rr_ptr       <= arb_next_ptr_c;
              packets_sent <= packets_inc_c;
            end else begin
              state              <= ST_GUARD_TRAIL;
              data_island_period <= 1'b0;
              guard              <= 1'b1;
              header             <= '0;
              sub                <= '0;
              slot_grant         <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_GUARD_TRAIL: begin
          if (cnt == CNT_W'(GUARD_LEN - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            guard <= 1'b0;
            busy  <= 1'b0;
            mask  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: stimulus queues expected slots,
// a negedge monitor pops and checks them as the DUT presents each slot.
module tb_packet_scheduler;

  localparam int unsigned NUM_REQ = 4;

  logic                   clk_pixel = 1'b0;
  logic                   reset_n;
  logic                   island_start;
  logic [4:0]             room_packets;
  logic                   must_send;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*24-1:0]  req_header;
  logic [NUM_REQ*224-1:0] req_sub;
  logic [NUM_REQ-1:0]     grant_ack;
  logic [23:0]            header;
  logic [3:0][55:0]       sub;
  logic                   preamble;
  logic                   guard;
  logic                   data_island_period;
  logic                   busy;

  packet_scheduler #(.NUM_REQ(NUM_REQ), .MAX_PACKETS(18)) dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .island_start       (island_start),
    .room_packets       (room_packets),
    .must_send          (must_send),
    .req                (req),
    .req_header         (req_header),
    .req_sub            (req_sub),
    .grant_ack          (grant_ack),
    .header             (header),
    .sub                (sub),
    .preamble           (preamble),
    .guard              (guard),
    .data_island_period (data_island_period),
    .busy               (busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] sb;
    logic [3:0]   ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  function automatic logic [23:0] hdr_of(input int i);
    return 24'h5A0000 + 24'(i * 257 + 1);
  endfunction

  function automatic logic [223:0] sub_of(input int i);
    logic [223:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s[56*k +: 56] = 56'hC0FFEE00000000 + 56'(i * 16 + k + 1);
    return s;
  endfunction

  task automatic push_slot(input int idx);
    exp_t e;
    if (idx < 0) begin
      e.hdr = '0; e.sb = '0; e.ack = '0;
    end else begin
      e.hdr = hdr_of(idx); e.sb = sub_of(idx); e.ack = 4'(1) << idx;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_pixel);
      n++;
    end
    check("idle_timeout", 256'(busy), 256'(0));
  endtask

  task automatic run_island(input logic [4:0] room);
    @(negedge clk_pixel);
    island_start = 1'b1;
    room_packets = room;
    @(negedge clk_pixel);
    island_start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
    wait_idle();
  endtask

  task automatic expect_no_island(input logic [4:0] room);
    @(negedge clk_pixel);
    island_start = 1'b1;
    room_packets = room;
    @(negedge clk_pixel);
    island_start = 1'b0;
    repeat (10) begin
      check("no_island_busy", 256'(busy), 256'(0));
      check("no_island_preamble", 256'(preamble), 256'(0));
      @(negedge clk_pixel);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_preamble"}, 256'(preamble), 256'(0));
    check({tag, "_guard"}, 256'(guard), 256'(0));
    check({tag, "_dip"}, 256'(data_island_period), 256'(0));
    check({tag, "_ack"}, 256'(grant_ack), 256'(0));
    check({tag, "_header"}, 256'(header), 256'(0));
    check({tag, "_sub"}, 256'(sub), 256'(0));
  endtask

  // Monitor: period lengths, per-slot payload and ack against the expected queue.
  initial begin
    int   pre_run, g_run, dip_run, ph;
    bit   have_cur;
    exp_t cur;
    logic [3:0] want_ack;
    pre_run = 0; g_run = 0; dip_run = 0; ph = 0; have_cur = 0;
    cur.hdr = '0; cur.sb = '0; cur.ack = '0;
    forever begin
      @(negedge clk_pixel);
      if (!reset_n) begin
        pre_run = 0; g_run = 0; dip_run = 0; ph = 0; have_cur = 0;
      end else begin
        if (preamble) pre_run++;
        else if (pre_run != 0) begin
          check("preamble_len", 256'(pre_run), 256'(8));
          pre_run = 0;
        end
        if (guard) g_run++;
        else if (g_run != 0) begin
          check("guard_len", 256'(g_run), 256'(2));
          g_run = 0;
        end
        if (data_island_period) begin
          if (ph == 0) begin
            if (exp_q.size() == 0) begin
              checks++; fails++; have_cur = 0;
              $display("FAIL unexpected_slot: got slot header %0h expected none (t=%0t)", header, $time);
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1;
              check("slot_header", 256'(header), 256'(cur.hdr));
              check("slot_sub", 256'(sub), 256'(cur.sb));
            end
          end
          if (ph == 31 && have_cur) begin
            check("slot_header_held", 256'(header), 256'(cur.hdr));
            check("slot_sub_held", 256'(sub), 256'(cur.sb));
          end
          want_ack = (ph == 31 && have_cur) ? cur.ack : 4'b0000;
          check("grant_ack", 256'(grant_ack), 256'(want_ack));
          dip_run++;
          ph = (ph + 1) % 32;
        end else begin
          check("ack_outside_slot", 256'(grant_ack), 256'(0));
          if (dip_run != 0) begin
            check("dip_len_mod32", 256'(dip_run % 32), 256'(0));
            dip_run = 0;
            ph = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int n;
    reset_n = 1'b0; island_start = 1'b0; room_packets = '0; must_send = 1'b0; req = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_header[24*i +: 24]  = hdr_of(i);
      req_sub[224*i +: 224]   = sub_of(i);
    end
    repeat (3) @(negedge clk_pixel);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk_pixel);
      check("idle_busy", 256'(busy), 256'(0));
      check("idle_dip", 256'(data_island_period), 256'(0));
    end

    // All four requesting, large room: one slot each per island, RR order.
    req = 4'b1111;
    push_slot(0); push_slot(1); push_slot(2); push_slot(3);
    run_island(5'd18);
    push_slot(0); push_slot(1); push_slot(2); push_slot(3);
    run_island(5'd18);

    // Room limits island to two slots; next island resumes at requester 2.
    push_slot(0); push_slot(1);
    run_island(5'd2);
    push_slot(2); push_slot(3);
    run_island(5'd2);
    req = 4'b0000;

    // Single requester; its data changes after grant must not show up.
    req = 4'b0010;
    push_slot(1);
    @(negedge clk_pixel);
    island_start = 1'b1; room_packets = 5'd3;
    @(negedge clk_pixel);
    island_start = 1'b0;
    n = 0;
    while (!data_island_period && n < 50) begin @(negedge clk_pixel); n++; end
    check("dip_rise_t4", 256'(data_island_period), 256'(1));
    repeat (3) @(negedge clk_pixel);
    req_header[24 +: 24] = 24'hFFFFFF;
    req_sub[224 +: 224]  = '1;
    wait_idle();
    req = 4'b0000;
    req_header[24 +: 24] = hdr_of(1);
    req_sub[224 +: 224]  = sub_of(1);

    // must_send with no request: one null slot; without must_send: nothing.
    must_send = 1'b1;
    push_slot(-1);
    run_island(5'd1);
    must_send = 1'b0;
    expect_no_island(5'd4);

    // Zero room ignores island_start; room of one gives exactly one slot.
    req = 4'b0001;
    expect_no_island(5'd0);
    req = 4'b1111;
    push_slot(2);
    run_island(5'd1);
    req = 4'b0000;

    // Reset mid-slot: immediate clear, no ack; fresh island serves requester 1 again.
    req = 4'b0010;
    push_slot(1);
    @(negedge clk_pixel);
    island_start = 1'b1; room_packets = 5'd3;
    @(negedge clk_pixel);
    island_start = 1'b0;
    n = 0;
    while (!data_island_period && n < 50) begin @(negedge clk_pixel); n++; end
    check("dip_rise_t7", 256'(data_island_period), 256'(1));
    repeat (15) @(negedge clk_pixel);
    #2 reset_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(negedge clk_pixel);
    reset_n = 1'b1;
    push_slot(1);
    run_island(5'd3);
    req = 4'b0000;

    repeat (4) @(negedge clk_pixel);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
